alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Sequencer that drives the ALU from the instruction side.
- Accepts one decoded operation per valid/ready handshake and reads operands from an internal register file. It then presents opcode and operands to the ALU, waits for settle, and writes the ALU result and flags back.
- Returns the ALU opcode bus to NOP (0) after every operation, because the ALU evaluates on opcode change. Back-to-back identical opcodes therefore re-trigger correctly.

Parameters:
- DATA_W, 32, operand/result width
- NREGS, 8, register file depth
- REG_AW, 3, register address width (log2 NREGS)
- SETTLE_CYCLES, 2, cycles the opcode/operands are held before capture (1..15)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  operation request valid
- req_ready  out  1  controller can accept a request
- req_op  in  5  ALU opcode (1..18)
- req_rd  in  REG_AW  destination register
- req_rn  in  REG_AW  first operand register
- req_rm  in  REG_AW  second operand register
- req_imm_en  in  1  use zero-extended req_imm as num2 instead of R[rm]
- req_imm  in  8  immediate
- alu_instruction  out  5  to ALU instruction
- alu_num1  out  DATA_W  to ALU num1
- alu_num2  out  DATA_W  to ALU num2
- alu_result  in  DATA_W  from ALU result
- alu_flags  in  4  from ALU flags {V,C,Z,N} (bit0=N, bit1=Z, bit2=C, bit3=V)
- done  out  1  one-cycle pulse, operation retired
- err  out  1  one-cycle pulse, illegal opcode rejected
- apsr  out  4  architectural flags register
- dbg_addr  in  REG_AW  debug read address
- dbg_data  out  DATA_W  R[dbg_addr], combinational read

Behaviour:
- Reset (rst_n=0 at a clk edge) sets the following, from any state, including mid-operation:
  - state=IDLE, all registers 0, apsr=0
  - alu_instruction=0, alu_num1=0, alu_num2=0
  - done=0, err=0
  - req_ready=1 the cycle after reset releases
- States: IDLE, ISSUE, WAIT, CAPTURE, CLEAR.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch op/rd/rn/rm/imm_en/imm, read R[rn] and the second operand into operand registers, then go to ISSUE.
  - If op is 0 or 19..31: no latch, err pulses next cycle, stay IDLE.
- ISSUE:
  - alu_instruction=op, alu_num1=R[rn], alu_num2=imm_en ? {24'b0,imm} : R[rm].
  - Load counter=SETTLE_CYCLES-1, go to WAIT; if SETTLE_CYCLES==1, go directly to CAPTURE.
- WAIT:
  - Outputs held stable.
  - Decrement counter; at 0 go to CAPTURE.
- CAPTURE:
  - Sample alu_result/alu_flags.
  - Writeback for ops 1..17: R[rd] <= alu_result.
  - No writeback for op 18 (CMP).
  - Flag update for ops 1..13 and 18: apsr <= alu_flags.
  - No flag update for ops 14..17 (extends).
  - Go to CLEAR.
- CLEAR:
  - alu_instruction=0; alu_num1 and alu_num2 hold their values.
  - done=1 for exactly this cycle, then go to IDLE.
- Latency: handshake to done = SETTLE_CYCLES+2 cycles. Minimum request spacing = SETTLE_CYCLES+3 cycles.
- Hazards:
  - rd==rn or rd==rm: operands are sampled at accept, so the old value is used.
  - The next request sees the written value, because writeback completes before req_ready reasserts.
- req_ready=0 in all states except IDLE. req_valid outside IDLE is ignored; the requester must hold it.
- dbg_data:
  - Reflects the register array combinationally.
  - A write becomes visible the cycle after CAPTURE.
- Values are written exactly as received; no width extension. Immediates are always zero-extended.
- Carry-in for ADCS/SBCS is owned by the ALU's internal flags. apsr is a mirror only and is not fed back.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams (ANDS=1 .. CMP=18, NOP=0)
  - flag bit indices (NEG=0, ZERO=1, CARRY=2, OVF=3)
  - state enum
  - functions writes_rd(op), writes_flags(op), op_legal(op)
- Sub-module alu_regfile:
  - NREGS x DATA_W registers
  - two combinational read ports plus the debug port
  - one synchronous write port
  - synchronous active-low clear

Test Plan:
- Basic add: reset, R1=5, R2=7 (preloaded via ADDS with imm from R0=0). ADDS rd=3,rn=1,rm=2 -> done after SETTLE_CYCLES+2 cycles; R3=12; apsr=0000; alu_instruction returns to 0 in the done cycle.
- Back-to-back same opcode: two ADDS R4=R4+imm1, starting from R4=0 -> R4=2. The bench sees alu_instruction go 6,0,6,0.
- CMP without writeback: R1=3, R2=3; CMP rn=1,rm=2 -> R-file unchanged, apsr[ZERO]=1. A following UXTB on R5 leaves apsr unchanged.
- Illegal opcode: req_op=0 and req_op=25 -> err pulses one cycle each, req_ready stays 1, no register or apsr change, alu_instruction stays 0.
- Reset mid-operation: assert rst_n=0 during WAIT -> next cycle state IDLE, all registers and apsr 0, done never pulses, alu_instruction=0.
- Backpressure: hold req_valid=1 with a new op during WAIT -> not accepted until IDLE; accepted exactly once; result correct.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller.
//  - opcode encodings (NOP=0, ANDS=1 .. CMP=18)
//  - bit positions of the {V,C,Z,N} flag nibble
//  - controller state enum
//  - opcode classification helpers used by the sequencer
package alu_pkg;

   localparam logic [4:0] OP_NOP  = 5'd0;
   localparam logic [4:0] OP_ANDS = 5'd1;
   localparam logic [4:0] OP_EORS = 5'd2;
   localparam logic [4:0] OP_LSLS = 5'd3;
   localparam logic [4:0] OP_LSRS = 5'd4;
   localparam logic [4:0] OP_ASRS = 5'd5;
   localparam logic [4:0] OP_ADDS = 5'd6;
   localparam logic [4:0] OP_ADCS = 5'd7;
   localparam logic [4:0] OP_SUBS = 5'd8;
   localparam logic [4:0] OP_SBCS = 5'd9;
   localparam logic [4:0] OP_RORS = 5'd10;
   localparam logic [4:0] OP_ORRS = 5'd11;
   localparam logic [4:0] OP_BICS = 5'd12;
   localparam logic [4:0] OP_MVNS = 5'd13;
   localparam logic [4:0] OP_SXTH = 5'd14;
   localparam logic [4:0] OP_SXTB = 5'd15;
   localparam logic [4:0] OP_UXTH = 5'd16;
   localparam logic [4:0] OP_UXTB = 5'd17;
   localparam logic [4:0] OP_CMP  = 5'd18;

   localparam int FLG_NEG   = 0;
   localparam int FLG_ZERO  = 1;
   localparam int FLG_CARRY = 2;
   localparam int FLG_OVF   = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_CAPTURE,
      ST_CLEAR
   } state_t;

   function automatic logic op_legal(input logic [4:0] op);
      return (op >= OP_ANDS) && (op <= OP_CMP);
   endfunction

   // Everything except CMP produces a register result.
   function automatic logic writes_rd(input logic [4:0] op);
      return (op >= OP_ANDS) && (op <= OP_UXTB);
   endfunction

   // Extends (14..17) leave the flags alone.
   function automatic logic writes_flags(input logic [4:0] op);
      return ((op >= OP_ANDS) && (op <= OP_MVNS)) || (op == OP_CMP);
   endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request channel into the ALU issue controller.
//  req_valid/req_ready : handshake
//  req_op              : ALU opcode
//  req_rd/rn/rm        : destination and source register addresses
//  req_imm_en/req_imm  : select zero-extended 8-bit immediate as num2
interface alu_issue_ctrl_if #(
   parameter int REG_AW = 3
);
   logic              req_valid;
   logic              req_ready;
   logic [4:0]        req_op;
   logic [REG_AW-1:0] req_rd;
   logic [REG_AW-1:0] req_rn;
   logic [REG_AW-1:0] req_rm;
   logic              req_imm_en;
   logic [7:0]        req_imm;

   modport master (
      output req_valid, req_op, req_rd, req_rn, req_rm, req_imm_en, req_imm,
      input  req_ready
   );

   modport slave (
      input  req_valid, req_op, req_rd, req_rn, req_rm, req_imm_en, req_imm,
      output req_ready
   );
endinterface

// File: rtl/alu_regfile.sv
// Register file for the ALU issue controller.
//  ra_addr/ra_data, rb_addr/rb_data : combinational operand read ports
//  dbg_addr/dbg_data                : combinational debug read port
//  we/waddr/wdata                   : synchronous write port
//  rst_n                            : synchronous active-low clear of all entries
module alu_regfile #(
   parameter int DATA_W = 32,
   parameter int NREGS  = 8,
   parameter int REG_AW = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] ra_addr,
   output logic [DATA_W-1:0] ra_data,
   input  logic [REG_AW-1:0] rb_addr,
   output logic [DATA_W-1:0] rb_data,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [DATA_W-1:0] wdata
);

   logic [DATA_W-1:0] regs_q [NREGS];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else if (we) begin
         regs_q[waddr] <= wdata;
      end
   end

   assign ra_data  = regs_q[ra_addr];
   assign rb_data  = regs_q[rb_addr];
   assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts one decoded op per handshake, reads operands
// from the register file, presents them to an external ALU for SETTLE_CYCLES,
// then captures result/flags and returns the opcode bus to NOP.
//  clk, rst_n         : clock, synchronous active-low reset
//  req                : request channel (slave side)
//  alu_instruction    : opcode to ALU, NOP outside ISSUE/WAIT/CAPTURE
//  alu_num1/alu_num2  : operands to ALU, held after the op retires
//  alu_result/flags   : ALU outputs, sampled in CAPTURE
//  done / err         : one-cycle retire / illegal-opcode pulses
//  apsr               : architectural flag mirror {V,C,Z,N}
//  dbg_addr/dbg_data  : combinational register-file peek
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int DATA_W        = 32,
   parameter int NREGS         = 8,
   parameter int REG_AW        = 3,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   alu_issue_ctrl_if.slave   req,
   output logic [4:0]        alu_instruction,
   output logic [DATA_W-1:0] alu_num1,
   output logic [DATA_W-1:0] alu_num2,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [3:0]        alu_flags,
   output logic              done,
   output logic              err,
   output logic [3:0]        apsr,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [4:0]        op_q, op_d;
   logic [REG_AW-1:0] rd_q, rd_d;
   logic [DATA_W-1:0] num1_q, num1_d;
   logic [DATA_W-1:0] num2_q, num2_d;
   logic [3:0]        apsr_q, apsr_d;
   logic              err_q, err_d;

   logic [DATA_W-1:0] rf_a, rf_b;
   logic              rf_we;

   alu_regfile #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS),
      .REG_AW (REG_AW)
   ) u_rf (
      .clk      (clk),
      .rst_n    (rst_n),
      .ra_addr  (req.req_rn),
      .ra_data  (rf_a),
      .rb_addr  (req.req_rm),
      .rb_data  (rf_b),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data),
      .we       (rf_we),
      .waddr    (rd_q),
      .wdata    (alu_result)
   );

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_q    <= OP_NOP;
         rd_q    <= '0;
         num1_q  <= '0;
         num2_q  <= '0;
         apsr_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         rd_q    <= rd_d;
         num1_q  <= num1_d;
         num2_q  <= num2_d;
         apsr_q  <= apsr_d;
         err_q   <= err_d;
      end
   end

   // Next state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      rd_d    = rd_q;
      num1_d  = num1_q;
      num2_d  = num2_q;
      apsr_d  = apsr_q;
      err_d   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (req.req_valid) begin
               if (op_legal(req.req_op)) begin
                  // Operands are snapshotted here, so rd==rn/rm hazards see the
                  // pre-write value; imm_en/imm are folded straight into num2.
                  op_d    = req.req_op;
                  rd_d    = req.req_rd;
                  num1_d  = rf_a;
                  num2_d  = req.req_imm_en ? {{(DATA_W-8){1'b0}}, req.req_imm} : rf_b;
                  state_d = ST_ISSUE;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_ISSUE: begin
            cnt_d   = CNT_LOAD;
            state_d = (SETTLE_CYCLES == 1) ? ST_CAPTURE : ST_WAIT;
         end
         ST_WAIT: begin
            // ISSUE plus SETTLE_CYCLES-1 WAIT cycles gives SETTLE_CYCLES of hold.
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            if (writes_flags(op_q)) apsr_d = alu_flags;
            state_d = ST_CLEAR;
         end
         ST_CLEAR: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      req.req_ready   = (state_q == ST_IDLE);
      done            = (state_q == ST_CLEAR);
      rf_we           = (state_q == ST_CAPTURE) && writes_rd(op_q);
      alu_instruction = OP_NOP;
      if (state_q == ST_ISSUE || state_q == ST_WAIT || state_q == ST_CAPTURE)
         alu_instruction = op_q;
   end

   assign alu_num1 = num1_q;
   assign alu_num2 = num2_q;
   assign apsr     = apsr_q;
   assign err      = err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  alu_instruction;
   logic [31:0] alu_num1, alu_num2, alu_result;
   logic [3:0]  alu_flags;
   logic        done, err;
   logic [3:0]  apsr;
   logic [2:0]  dbg_addr;
   logic [31:0] dbg_data;

   int n_vec = 0;
   int n_bad = 0;

   alu_issue_ctrl_if #(.REG_AW(3)) req_bus ();

   alu_issue_ctrl #(.DATA_W(32), .NREGS(8), .REG_AW(3), .SETTLE_CYCLES(2)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req             (req_bus),
      .alu_instruction (alu_instruction),
      .alu_num1        (alu_num1),
      .alu_num2        (alu_num2),
      .alu_result      (alu_result),
      .alu_flags       (alu_flags),
      .done            (done),
      .err             (err),
      .apsr            (apsr),
      .dbg_addr        (dbg_addr),
      .dbg_data        (dbg_data)
   );

   always #5 clk = ~clk;

   // Stand-in ALU for the ops the bench uses
   always_comb begin
      logic [32:0] w;
      w          = '0;
      alu_result = '0;
      alu_flags  = '0;
      case (alu_instruction)
         OP_ADDS: begin
            w = {1'b0, alu_num1} + {1'b0, alu_num2};
            alu_result = w[31:0];
            alu_flags  = {(alu_num1[31] == alu_num2[31]) && (w[31] != alu_num1[31]),
                          w[32], w[31:0] == 32'd0, w[31]};
         end
         OP_CMP: begin
            w = {1'b0, alu_num1} - {1'b0, alu_num2};
            alu_result = w[31:0];
            alu_flags  = {(alu_num1[31] != alu_num2[31]) && (w[31] != alu_num1[31]),
                          ~w[32], w[31:0] == 32'd0, w[31]};
         end
         OP_UXTB: begin
            alu_result = {24'd0, alu_num1[7:0]};
            alu_flags  = 4'b0011; // deliberately nonzero: must not reach apsr
         end
         default: ;
      endcase
   end

   // Opcode-bus transition log
   logic       log_en = 1'b0;
   logic [4:0] last_ins = 5'd0;
   logic [4:0] ins_log[$];
   always @(negedge clk) begin
      if (log_en && alu_instruction != last_ins) ins_log.push_back(alu_instruction);
      last_ins = alu_instruction;
   end

   task automatic rd_reg(input logic [2:0] a, output logic [31:0] v);
      dbg_addr = a;
      #1 v = dbg_data;
   endtask

   // Issue one request and wait for done; lat=-1 on timeout.
   task automatic do_op(input logic [4:0] op, input logic [2:0] rd, rn, rm,
                        input logic ie, input logic [7:0] imm,
                        output int lat, output logic [4:0] ins_done,
                        output logic [31:0] n1, output logic [31:0] n2);
      int c;
      lat = -1; ins_done = 5'h1f; n1 = 'x; n2 = 'x;
      @(negedge clk);
      req_bus.req_valid = 1'b1; req_bus.req_op = op; req_bus.req_rd = rd;
      req_bus.req_rn = rn; req_bus.req_rm = rm; req_bus.req_imm_en = ie; req_bus.req_imm = imm;
      c = 0;
      while (!req_bus.req_ready && c < 20) begin @(negedge clk); c++; end
      @(posedge clk); #1 req_bus.req_valid = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (done) begin
            lat = i; ins_done = alu_instruction; n1 = alu_num1; n2 = alu_num2;
            break;
         end
      end
      if (lat < 0) $display("FAIL do_op timeout op=%0d", op);
   endtask

   task automatic test_reset();
      logic [31:0] v;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      n_vec++; if (req_bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", req_bus.req_ready); end
      n_vec++; if (alu_instruction !== 5'd0) begin n_bad++; $display("FAIL reset_instr got %0d want 0", alu_instruction); end
      n_vec++; if ({alu_num1, alu_num2} !== 64'd0) begin n_bad++; $display("FAIL reset_nums got %h %h want 0", alu_num1, alu_num2); end
      n_vec++; if ({done, err, apsr} !== 6'd0) begin n_bad++; $display("FAIL reset_done_err_apsr got %b%b %b want 00 0000", done, err, apsr); end
      for (int r = 0; r < 8; r++) begin
         rd_reg(3'(r), v);
         n_vec++; if (v !== 32'd0) begin n_bad++; $display("FAIL reset_R%0d got %0d want 0", r, v); end
      end
   endtask

   task automatic test_basic_add();
      int lat; logic [4:0] ins; logic [31:0] n1, n2, v;
      do_op(OP_ADDS, 3'd1, 3'd0, 3'd0, 1'b1, 8'd5, lat, ins, n1, n2);
      do_op(OP_ADDS, 3'd2, 3'd0, 3'd0, 1'b1, 8'd7, lat, ins, n1, n2);
      do_op(OP_ADDS, 3'd3, 3'd1, 3'd2, 1'b0, 8'd0, lat, ins, n1, n2);
      n_vec++; if (lat !== 4) begin n_bad++; $display("FAIL add_latency got %0d want 4", lat); end
      n_vec++; if (ins !== 5'd0) begin n_bad++; $display("FAIL add_instr_at_done got %0d want 0", ins); end
      n_vec++; if (n1 !== 32'd5 || n2 !== 32'd7) begin n_bad++; $display("FAIL add_nums_held got %0d %0d want 5 7", n1, n2); end
      rd_reg(3'd3, v);
      n_vec++; if (v !== 32'd12) begin n_bad++; $display("FAIL add_R3 got %0d want 12", v); end
      n_vec++; if (apsr !== 4'b0000) begin n_bad++; $display("FAIL add_apsr got %b want 0000", apsr); end
   endtask

   task automatic test_back_to_back();
      int lat; logic [4:0] ins; logic [31:0] n1, n2, v;
      logic [4:0] exp_seq [4];
      exp_seq = '{5'd6, 5'd0, 5'd6, 5'd0};
      ins_log.delete(); log_en = 1'b1;
      do_op(OP_ADDS, 3'd4, 3'd4, 3'd0, 1'b1, 8'd1, lat, ins, n1, n2);
      do_op(OP_ADDS, 3'd4, 3'd4, 3'd0, 1'b1, 8'd1, lat, ins, n1, n2);
      @(negedge clk); log_en = 1'b0;
      n_vec++; if (ins_log.size() !== 4) begin n_bad++; $display("FAIL b2b_log_len got %0d want 4", ins_log.size()); end
      for (int i = 0; i < 4 && i < ins_log.size(); i++) begin
         n_vec++; if (ins_log[i] !== exp_seq[i]) begin n_bad++; $display("FAIL b2b_instr[%0d] got %0d want %0d", i, ins_log[i], exp_seq[i]); end
      end
      rd_reg(3'd4, v);
      n_vec++; if (v !== 32'd2) begin n_bad++; $display("FAIL b2b_R4 got %0d want 2", v); end
   endtask

   task automatic test_cmp();
      int lat; logic [4:0] ins; logic [31:0] n1, n2, v;
      do_op(OP_ADDS, 3'd1, 3'd0, 3'd0, 1'b1, 8'd3, lat, ins, n1, n2);
      do_op(OP_ADDS, 3'd2, 3'd0, 3'd0, 1'b1, 8'd3, lat, ins, n1, n2);
      do_op(OP_CMP,  3'd3, 3'd1, 3'd2, 1'b0, 8'd0, lat, ins, n1, n2);
      rd_reg(3'd3, v);
      n_vec++; if (v !== 32'd12) begin n_bad++; $display("FAIL cmp_no_wb_R3 got %0d want 12", v); end
      rd_reg(3'd1, v);
      n_vec++; if (v !== 32'd3) begin n_bad++; $display("FAIL cmp_R1 got %0d want 3", v); end
      n_vec++; if (apsr[FLG_ZERO] !== 1'b1) begin n_bad++; $display("FAIL cmp_zero got %b want 1", apsr[FLG_ZERO]); end
      n_vec++; if (apsr !== 4'b0110) begin n_bad++; $display("FAIL cmp_apsr got %b want 0110", apsr); end
      do_op(OP_UXTB, 3'd5, 3'd1, 3'd0, 1'b0, 8'd0, lat, ins, n1, n2);
      rd_reg(3'd5, v);
      n_vec++; if (v !== 32'd3) begin n_bad++; $display("FAIL uxtb_R5 got %0d want 3", v); end
      n_vec++; if (apsr !== 4'b0110) begin n_bad++; $display("FAIL uxtb_apsr got %b want 0110", apsr); end
   endtask

   task automatic test_illegal();
      logic [4:0] ops [2];
      logic [31:0] v;
      ops = '{5'd0, 5'd25};
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         req_bus.req_valid = 1'b1; req_bus.req_op = ops[k]; req_bus.req_rd = 3'd5;
         req_bus.req_rn = 3'd0; req_bus.req_imm_en = 1'b1; req_bus.req_imm = 8'hAA;
         @(posedge clk); #1 req_bus.req_valid = 1'b0;
         @(negedge clk);
         n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL illegal%0d_err got %b want 1", ops[k], err); end
         n_vec++; if (req_bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL illegal%0d_ready got %b want 1", ops[k], req_bus.req_ready); end
         n_vec++; if (alu_instruction !== 5'd0) begin n_bad++; $display("FAIL illegal%0d_instr got %0d want 0", ops[k], alu_instruction); end
         @(negedge clk);
         n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL illegal%0d_err_pulse got %b want 0", ops[k], err); end
      end
      rd_reg(3'd5, v);
      n_vec++; if (v !== 32'd3) begin n_bad++; $display("FAIL illegal_R5 got %0d want 3", v); end
      n_vec++; if (apsr !== 4'b0110) begin n_bad++; $display("FAIL illegal_apsr got %b want 0110", apsr); end
   endtask

   task automatic test_reset_mid();
      int c; int dones; logic [31:0] v; int nz;
      @(negedge clk);
      req_bus.req_valid = 1'b1; req_bus.req_op = OP_ADDS; req_bus.req_rd = 3'd6;
      req_bus.req_rn = 3'd1; req_bus.req_imm_en = 1'b1; req_bus.req_imm = 8'd1;
      c = 0;
      while (!req_bus.req_ready && c < 20) begin @(negedge clk); c++; end
      @(posedge clk); #1 req_bus.req_valid = 1'b0;
      @(negedge clk); @(negedge clk); // now in WAIT
      n_vec++; if (alu_instruction !== OP_ADDS) begin n_bad++; $display("FAIL rstmid_wait_instr got %0d want 6", alu_instruction); end
      rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      n_vec++; if (alu_instruction !== 5'd0 || req_bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_idle got instr=%0d ready=%b want 0 1", alu_instruction, req_bus.req_ready); end
      n_vec++; if (apsr !== 4'd0 || alu_num1 !== 32'd0) begin n_bad++; $display("FAIL rstmid_apsr_num got %b %0d want 0000 0", apsr, alu_num1); end
      dones = 0;
      for (int i = 0; i < 8; i++) begin @(negedge clk); if (done) dones++; end
      n_vec++; if (dones !== 0) begin n_bad++; $display("FAIL rstmid_done got %0d pulses want 0", dones); end
      nz = 0;
      for (int r = 0; r < 8; r++) begin rd_reg(3'(r), v); if (v !== 32'd0) nz++; end
      n_vec++; if (nz !== 0) begin n_bad++; $display("FAIL rstmid_regs got %0d nonzero want 0", nz); end
   endtask

   task automatic test_backpressure();
      int c; int acc; int spacing; int dones; logic [31:0] v;
      @(negedge clk);
      req_bus.req_valid = 1'b1; req_bus.req_op = OP_ADDS; req_bus.req_rd = 3'd6;
      req_bus.req_rn = 3'd0; req_bus.req_imm_en = 1'b1; req_bus.req_imm = 8'd9;
      c = 0;
      while (!req_bus.req_ready && c < 20) begin @(negedge clk); c++; end
      @(posedge clk); #1;
      // second op held valid throughout the first
      req_bus.req_rn = 3'd6; req_bus.req_imm = 8'd1;
      acc = 0; spacing = -1; dones = 0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (done) dones++;
         if (i == 2) begin
            n_vec++; if (req_bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_in_wait got %b want 0", req_bus.req_ready); end
         end
         if (req_bus.req_valid && req_bus.req_ready) begin
            acc++;
            if (spacing < 0) spacing = i;
            @(posedge clk); #1 req_bus.req_valid = 1'b0;
         end
      end
      req_bus.req_valid = 1'b0;
      n_vec++; if (acc !== 1) begin n_bad++; $display("FAIL bp_accepts got %0d want 1", acc); end
      n_vec++; if (spacing !== 5) begin n_bad++; $display("FAIL bp_spacing got %0d want 5", spacing); end
      n_vec++; if (dones !== 2) begin n_bad++; $display("FAIL bp_dones got %0d want 2", dones); end
      rd_reg(3'd6, v);
      n_vec++; if (v !== 32'd10) begin n_bad++; $display("FAIL bp_R6 got %0d want 10", v); end
   endtask

   initial begin
      rst_n = 1'b0; dbg_addr = '0;
      req_bus.req_valid = 1'b0; req_bus.req_op = '0; req_bus.req_rd = '0;
      req_bus.req_rn = '0; req_bus.req_rm = '0; req_bus.req_imm_en = 1'b0; req_bus.req_imm = '0;
      test_reset();
      test_basic_add();
      test_back_to_back();
      test_cmp();
      test_illegal();
      test_reset_mid();
      test_backpressure();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
